param_stream_loader: RTL and testbench

Streaming parameter sink: accepts a valid/ready stream of parallel weight beats and writes each beat as one row into an internal RAM. Once a full tensor has landed, it serves the rows through a registered 2-cycle read port. It is the write-side counterpart of the per-layer ROM weight sources. It lets a host or DMA stream reload layer weights at runtime, and downstream readers see the same address/latency behaviour as the ROM sources.

---
 rtl/param_stream_loader_pkg.sv | 15 +
 rtl/param_stream_loader_ram.sv | 47 ++++
 rtl/param_stream_loader.sv | 97 +++++++++
 tb/tb_param_stream_loader.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/param_stream_loader_pkg.sv
// Shared types for stream-fed parameter sinks: lane element and load FSM states.
package param_stream_loader_pkg;

    // Default width of one weight element in a beat lane
    localparam int LANE_PRECISION = 16;

    typedef logic [LANE_PRECISION-1:0] lane_t;

    // Sink lifecycle: accepting beats, or holding a complete tensor
    typedef enum logic {
        LOAD = 1'b0,
        DONE = 1'b1
    } load_state_t;

endpackage

// File: rtl/param_stream_loader_ram.sv
// Simple dual-port row RAM: one write port, one two-stage registered read port with ce.
module param_stream_loader_ram #(
    parameter int WIDTH         = 64,
    parameter int DEPTH         = 8,
    parameter int RD_ADDR_WIDTH = $clog2(DEPTH) + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_ce,
    input  logic [RD_ADDR_WIDTH-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_q1;
    logic             rd_in_range;

    // Addresses past the tensor read as zero; the top bit of rd_addr only selects that case
    assign rd_in_range = (rd_addr < RD_ADDR_WIDTH'(DEPTH));

    // Write port: one row per accepted beat
    // NOTE: the array has no reset branch on purpose; resetting a memory turns it into
    // flops and breaks block-RAM inference, and old rows must survive rst anyway.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Two-stage read pipeline: RAM output register, then output register, both gated by rd_ce.
    // Reading mem with <= alongside the write gives read-before-write on a same-row collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q1   <= '0;
            rd_data <= '0;
        end else if (rd_ce) begin
            rd_q1   <= rd_in_range ? mem[rd_addr[AW-1:0]] : '0;
            rd_data <= rd_q1;
        end
    end

endmodule

// File: rtl/param_stream_loader.sv
// Streaming parameter sink: writes DEPTH valid/ready beats as RAM rows, then serves
// them through a 2-cycle registered read port matching the ROM weight sources.
module param_stream_loader
    import param_stream_loader_pkg::*;
#(
    parameter int PRECISION   = LANE_PRECISION,
    parameter int PARALLELISM = 4,
    parameter int DEPTH       = 8,
    parameter int ADDR_WIDTH  = $clog2(DEPTH) + 1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  clear,
    input  logic [PARALLELISM-1:0][PRECISION-1:0] data_in,
    input  logic                                  data_in_valid,
    output logic                                  data_in_ready,
    output logic                                  load_done,
    output logic [ADDR_WIDTH-1:0]                 loaded_rows,
    input  logic                                  rd_ce,
    input  logic [ADDR_WIDTH-1:0]                 rd_addr,
    output logic [PRECISION*PARALLELISM-1:0]      rd_data
);

    localparam int ROW_WIDTH = PRECISION * PARALLELISM;
    localparam int RAM_AW    = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ROW = ADDR_WIDTH'(DEPTH - 1);

    load_state_t           state;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ROW_WIDTH-1:0]  wr_row;
    logic                  wr_en;

    // A beat lands only in LOAD; clear and rst both win over a beat in the same cycle
    assign wr_en = (state == LOAD) && data_in_valid && !clear && !rst;

    assign loaded_rows = wr_ptr;

    // Lane packing: lane j occupies row bits [PRECISION*j +: PRECISION]
    always_comb begin
        // NOTE: assign a default before the loop so every path drives wr_row and no latch is inferred.
        wr_row = '0;
        for (int j = 0; j < PARALLELISM; j++) begin
            wr_row[PRECISION*j +: PRECISION] = data_in[j];
        end
    end

    // Load FSM with row pointer; ready/done are registered and depend only on state
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= LOAD;
            wr_ptr        <= '0;
            data_in_ready <= 1'b1;
            load_done     <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (clear) begin
                        wr_ptr <= '0;
                    end else if (data_in_valid) begin
                        // Pointer stops at DEPTH after the last row; it never wraps
                        wr_ptr <= wr_ptr + 1'b1;
                        if (wr_ptr == LAST_ROW) begin
                            state         <= DONE;
                            data_in_ready <= 1'b0;
                            load_done     <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (clear) begin
                        state         <= LOAD;
                        wr_ptr        <= '0;
                        data_in_ready <= 1'b1;
                        load_done     <= 1'b0;
                    end
                end
            endcase
        end
    end

    param_stream_loader_ram #(
        .WIDTH         (ROW_WIDTH),
        .DEPTH         (DEPTH),
        .RD_ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr[RAM_AW-1:0]),
        .wr_data (wr_row),
        .rd_ce   (rd_ce),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_param_stream_loader.sv
// Scoreboard bench for param_stream_loader: directed scenarios plus a random phase,
// checked against a behavioural model of the load rules and the read latency.
module tb_param_stream_loader;
    import param_stream_loader_pkg::*;

    localparam int PRECISION   = 16;
    localparam int PARALLELISM = 4;
    localparam int DEPTH       = 8;
    localparam int ADDR_WIDTH  = $clog2(DEPTH) + 1;

    typedef logic [PARALLELISM-1:0][PRECISION-1:0] beat_t;
    typedef struct {
        beat_t data;
        bit    chk;
        int    addr;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  clear;
    beat_t                 data_in;
    logic                  data_in_valid;
    logic                  data_in_ready;
    logic                  load_done;
    logic [ADDR_WIDTH-1:0] loaded_rows;
    logic                  rd_ce;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [PRECISION*PARALLELISM-1:0] rd_data;

    param_stream_loader #(
        .PRECISION   (PRECISION),
        .PARALLELISM (PARALLELISM),
        .DEPTH       (DEPTH),
        .ADDR_WIDTH  (ADDR_WIDTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .clear         (clear),
        .data_in       (data_in),
        .data_in_valid (data_in_valid),
        .data_in_ready (data_in_ready),
        .load_done     (load_done),
        .loaded_rows   (loaded_rows),
        .rd_ce         (rd_ce),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];
    bit   rd_req = 1'b0;

    // Reference model: tensor rows, which rows hold known data, rows loaded, tensor complete
    beat_t model_mem [DEPTH];
    bit    model_known [DEPTH];
    int    model_rows = 0;
    bit    model_done = 1'b0;

    // Monitor bookkeeping: an issued read is pending its second enabled edge
    bit mon_pending = 1'b0;
    bit mon_due     = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic beat_t pattern(input int k);
        beat_t b;
        for (int j = 0; j < PARALLELISM; j++) begin
            b[j] = lane_t'(4 * k + j);
        end
        return b;
    endfunction

    function automatic beat_t rand_beat();
        return beat_t'({$urandom, $urandom});
    endfunction

    // Apply the load rules for one clock edge using the inputs currently driven
    function automatic void model_edge();
        if (rst) begin
            model_rows = 0;
            model_done = 1'b0;
        end else if (model_done) begin
            if (clear) begin
                model_done = 1'b0;
                model_rows = 0;
            end
        end else if (clear) begin
            model_rows = 0;
        end else if (data_in_valid) begin
            model_mem[model_rows]   = data_in;
            model_known[model_rows] = 1'b1;
            model_rows++;
            if (model_rows == DEPTH) model_done = 1'b1;
        end
    endfunction

    // One clock: drive inputs, queue any read expectation (before the write: read-before-write),
    // advance the model, then wait to the falling edge where outputs are sampled
    task automatic tick(input bit v, input beat_t beat, input bit clr,
                        input bit ce, input bit req, input int addr);
        exp_t e;
        data_in_valid = v;
        data_in       = beat;
        clear         = clr;
        rd_ce         = ce;
        rd_req        = ce && req;
        rd_addr       = ADDR_WIDTH'(addr);
        if (ce && req) begin
            e.addr = addr;
            e.chk  = (addr < DEPTH) && model_known[addr];
            e.data = e.chk ? model_mem[addr] : '0;
            sb_q.push_back(e);
        end
        model_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        tick(1'b0, '0, 1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic read_row(input int r);
        tick(1'b0, '0, 1'b0, 1'b1, 1'b1, r);
    endtask

    task automatic drain();
        for (int i = 0; i < 3; i++) tick(1'b0, '0, 1'b0, 1'b1, 1'b0, 0);
    endtask

    task automatic check_status(input string tag);
        check({tag, "_ready"}, 64'(data_in_ready), 64'(!model_done));
        check({tag, "_done"}, 64'(load_done), 64'(model_done));
        check({tag, "_rows"}, 64'(loaded_rows), 64'(model_rows));
    endtask

    task automatic read_all(input string tag);
        for (int r = 0; r < DEPTH; r++) read_row(r);
        drain();
        check({tag, "_sb_empty"}, 64'(sb_q.size()), 64'd0);
    endtask

    // Monitor: pops the oldest expectation each time a read result reaches rd_data
    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                mon_pending = 1'b0;
                mon_due     = 1'b0;
                sb_q.delete();
            end else if (rd_ce) begin
                mon_due     = mon_pending;
                mon_pending = rd_req;
            end else begin
                mon_due = 1'b0;
            end
            @(negedge clk);
            if (mon_due) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_underflow actual=empty expected=entry");
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    if (e.chk) check($sformatf("rd_row%0d", e.addr), rd_data, e.data);
                end
            end
        end
    end

    initial begin
        beat_t keep_row1;
        int    beats;
        int    guard;

        rst = 1'b1;
        clear = 1'b0;
        data_in_valid = 1'b0;
        data_in = '0;
        rd_ce = 1'b0;
        rd_addr = '0;
        idle();
        idle();
        check_status("reset");
        check("reset_rd_data", rd_data, 64'd0);
        rst = 1'b0;

        // Full load with valid held high; the two extra beats must be refused
        for (int k = 0; k < DEPTH + 2; k++) begin
            tick(1'b1, pattern(k), 1'b0, 1'b0, 1'b0, 0);
            check_status($sformatf("full_load%0d", k));
        end
        read_all("full");
        tick(1'b0, '0, 1'b0, 1'b1, 1'b1, 5);
        tick(1'b0, '0, 1'b0, 1'b1, 1'b0, 0);
        check("row5_const", rd_data, 64'h0017_0016_0015_0014);
        drain();

        // Overflow attempt while DONE
        for (int k = 0; k < 3; k++) begin
            tick(1'b1, {PARALLELISM{16'hFFFF}}, 1'b0, 1'b0, 1'b0, 0);
            check_status($sformatf("overflow%0d", k));
        end
        read_row(0);
        drain();

        // Read stall: rd_data must hold row 1 while rd_ce is low
        keep_row1 = model_mem[1];
        read_row(1);
        read_row(2);
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, '0, 1'b0, 1'b0, 1'b0, 3);
            check($sformatf("stall_hold%0d", i), rd_data, keep_row1);
        end
        read_row(3);
        drain();

        // Valid gaps: clear out of DONE, then reload with valid every other cycle
        tick(1'b0, '0, 1'b1, 1'b0, 1'b0, 0);
        check_status("clear_done");
        for (int c = 0; c < 2 * DEPTH; c++) begin
            tick((c % 2) == 0, pattern(c / 2), 1'b0, 1'b0, 1'b0, 0);
            check_status($sformatf("gaps%0d", c));
        end
        read_all("gaps");

        // clear arriving with the 4th beat drops it; reload with random rows
        tick(1'b0, '0, 1'b1, 1'b0, 1'b0, 0);
        for (int k = 0; k < 3; k++) tick(1'b1, rand_beat(), 1'b0, 1'b0, 1'b0, 0);
        tick(1'b1, rand_beat(), 1'b1, 1'b0, 1'b0, 0);
        check_status("clear_mid");
        guard = 0;
        while (!model_done && guard < 64) begin
            tick(($urandom % 4) != 0, rand_beat(), 1'b0, 1'b0, 1'b0, 0);
            guard++;
        end
        check_status("reload");
        read_all("reload");

        // rst after 5 beats: outputs return to reset values, written rows survive
        tick(1'b0, '0, 1'b1, 1'b0, 1'b0, 0);
        for (int k = 0; k < 5; k++) tick(1'b1, rand_beat(), 1'b0, 1'b0, 1'b0, 0);
        read_row(2);
        read_row(6);
        rst = 1'b1;
        idle();
        check_status("rst_mid");
        check("rst_mid_rd_data", rd_data, 64'd0);
        rst = 1'b0;
        read_all("after_rst");
        for (int k = 0; k < 2; k++) tick(1'b1, rand_beat(), 1'b0, 1'b0, 1'b0, 0);
        check_status("rewrite");
        read_all("rewrite");

        // Random mix: gaps, occasional clear, reads (some out of range) overlapping writes
        for (int c = 0; c < 400; c++) begin
            tick(($urandom % 3) != 0, rand_beat(), ($urandom % 24) == 0,
                 ($urandom % 4) != 0, ($urandom % 2) == 0, int'($urandom % (2 * DEPTH)));
            check_status($sformatf("rand%0d", c));
        end
        beats = 0;
        while (sb_q.size() != 0 && beats < 10) begin
            tick(1'b0, '0, 1'b0, 1'b1, 1'b0, 0);
            beats++;
        end
        check("final_sb_empty", 64'(sb_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
